// File: rtl/circuit_pipe.sv
//==============================================================================
// Module   : circuit_pipe
// Purpose  : Two-register arithmetic pipeline with a valid/ready handshake on
//            both sides. Stage 0 forms sums, a difference and a compare.
//            Stage 1 registers the selected values. Stage 2 applies
//            flag-controlled shifts into the output register. A saturating
//            counter tracks accepted transactions where a+b == a+c.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-low reset
//            mode       compare mode (0 unsigned, 1 signed), sampled on accept
//            a, b, c    operands (DATAWIDTH)
//            in_valid   operands valid
//            in_ready   block accepts operands this cycle
//            x, z       results (OUTWIDTH)
//            out_valid  x/z hold a valid result
//            out_ready  consumer accepts the result
//            cnt_clr    synchronous clear of eq_cnt
//            eq_cnt     saturating count of accepted transactions with d == e
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module circuit_pipe #(
   parameter int DATAWIDTH = 64,
   parameter int OUTWIDTH  = 32,
   parameter int SHAMT     = 1,
   parameter int CNTWIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUTWIDTH-1:0]  x,
   output logic [OUTWIDTH-1:0]  z,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 cnt_clr,
   output logic [CNTWIDTH-1:0]  eq_cnt
);

   localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

   // Stage 0: combinational arithmetic on the raw operands
   logic [DATAWIDTH-1:0] d, e, f, g, h;
   logic                 eq, lt;

   always_comb begin
      d  = a + b;
      e  = a + c;
      f  = a - b;
      eq = (d == e);
      lt = mode ? ($signed(d) < $signed(e)) : (d < e);
      g  = lt ? d : e;
      h  = eq ? g : f;
   end

   // Handshake control
   logic s1_valid;
   logic accept;
   logic load_out;

   // Accepting is safe whenever stage 1 is empty or is guaranteed to move
   // into the output register on this same edge.
   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign load_out = s1_valid && (!out_valid || out_ready);

   // Stage 1 valid flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
      end else if (load_out) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 1 data: contents are meaningless while s1_valid is low, so no reset
   logic [DATAWIDTH-1:0] s1_g, s1_h;
   logic                 s1_lt, s1_eq;

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_g  <= g;
         s1_h  <= h;
         s1_lt <= lt;
         s1_eq <= eq;
      end
   end

   // Stage 2: flag-controlled logical shifts, zero fill
   logic [DATAWIDTH-1:0] xs, zs;

   always_comb begin
      xs = s1_lt ? (s1_h << SHAMT) : s1_h;
      zs = s1_eq ? (s1_g >> SHAMT) : s1_g;
   end

   // Output register: holds while the consumer stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         x         <= '0;
         z         <= '0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         x         <= xs[OUTWIDTH-1:0];
         z         <= zs[OUTWIDTH-1:0];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating equality counter; clear wins over a simultaneous increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eq_cnt <= '0;
      end else if (cnt_clr) begin
         eq_cnt <= '0;
      end else if (accept && eq && (eq_cnt != CNT_MAX)) begin
         eq_cnt <= eq_cnt + CNTWIDTH'(1);
      end
   end

endmodule

`default_nettype wire
